// File: rtl/seq_mem_bank_if.sv
// Bus bundle for seq_mem_bank_mp: masked write ports,
// registered read port and the sweep-clear handshake.
interface seq_mem_bank_if #(
  parameter int WIDTH = 8,
  parameter int NWR   = 2,
  parameter int AW    = 4
);
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*WIDTH-1:0] wr_data;
  logic [NWR*WIDTH-1:0] wr_mask;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_valid;
  logic                 clr_req;
  logic                 clr_busy;
  logic                 clr_done;
  logic                 oob_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask,
    output rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid,
    input  clr_busy, clr_done, oob_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask,
    input  rd_en, rd_addr, clr_req,
    output rd_data, rd_valid,
    output clr_busy, clr_done, oob_err
  );
endinterface

// File: rtl/seq_mem_bank_mp.sv
// Multi-port memory bank: NWR masked write ports,
// one registered read port and a sweep-clear FSM.
module seq_mem_bank_mp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NWR   = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic          clk,
  input logic          rst_n,
  seq_mem_bank_if.slave bus
);

  localparam logic [AW:0] DEP  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [AW:0]     clr_idx, clr_idx_n;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wa    [NWR];
  logic [WIDTH-1:0] wd    [NWR];
  logic [WIDTH-1:0] wm    [NWR];
  logic [WIDTH-1:0] wword [NWR];
  logic [NWR-1:0]   wr_in;
  logic [NWR-1:0]   wr_ok;
  logic             rd_in;

  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wa[p]    = bus.wr_addr[p*AW +: AW];
      wd[p]    = bus.wr_data[p*WIDTH +: WIDTH];
      wm[p]    = bus.wr_mask[p*WIDTH +: WIDTH];
      wr_in[p] = {1'b0, wa[p]} < DEP;
    end
  end

  assign wr_ok = bus.wr_en & wr_in
               & {NWR{state == IDLE}};
  assign rd_in = {1'b0, bus.rd_addr} < DEP;

  // Every port hitting the same word computes the same
  // merged value; ascending order lets the top port win.
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wword[p] = wr_in[p] ? mem[wa[p]] : '0;
      for (int q = 0; q < NWR; q++) begin
        if (wr_ok[q] && wa[q] == wa[p]) begin
          wword[p] = (wword[p] & ~wm[q])
                   | (wd[q] & wm[q]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx[AW-1:0]] <= '0;
    end
    for (int p = 0; p < NWR; p++) begin
      if (wr_ok[p]) begin
        mem[wa[p]] <= wword[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.oob_err  <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= rd_in ? mem[bus.rd_addr] : '0;
      end
      bus.oob_err <= (|(bus.wr_en & ~wr_in))
                   | (bus.rd_en & ~rd_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_n;
      clr_idx <= clr_idx_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_idx_n = clr_idx;
    unique case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_n   = CLEAR;
          clr_idx_n = '0;
        end
      end
      CLEAR: begin
        clr_idx_n = clr_idx + ONE;
        if (clr_idx == LAST) begin
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.clr_busy = (state == CLEAR);
  assign bus.clr_done = (state == DONE);

endmodule
